// File: rtl/tx_fc_credit_checker_if.sv
// Tx arbiter <-> flow-control handshake: up to two TLP requests per cycle and the grant result.
interface tx_fc_credit_checker_if;
  logic [9:0] PTLP_1;
  logic [9:0] PTLP_2;
  logic [1:0] Command_1;
  logic [1:0] Command_2;
  logic [1:0] Result;

  modport master (output PTLP_1, PTLP_2, Command_1, Command_2, input Result);
  modport slave  (input PTLP_1, PTLP_2, Command_1, Command_2, output Result);
endinterface

// File: rtl/tx_fc_credit_checker.sv
// Tracks PCIe credit limits/consumption per type and grants up to two in-order TLPs per
// cycle using the modulo credit check.
module tx_fc_credit_checker #(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  tx_fc_credit_checker_if.slave    arb,
  input  logic                     fc_update_valid,
  input  logic                     fc_update_init,
  input  logic [1:0]               fc_update_type,
  input  logic [FC_HDR_WIDTH-1:0]  fc_update_hdr,
  input  logic [FC_DATA_WIDTH-1:0] fc_update_data,
  output logic                     fc_initialized
);
  localparam int HW = FC_HDR_WIDTH;
  localparam int DW = FC_DATA_WIDTH;
  localparam logic [HW-1:0] HDR_HALF = {1'b1, {(HW-1){1'b0}}};
  localparam logic [DW-1:0] DATA_HALF = {1'b1, {(DW-1){1'b0}}};
  localparam logic [HW-1:0] HDR_ONE = {{(HW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FC_NOP = 2'b00, FC_P = 2'b01, FC_NP = 2'b10, FC_CPL = 2'b11} fc_command_t;
  typedef enum logic [1:0] {FC_FAILED = 2'b00, FC_SUCCESS_1 = 2'b01, FC_SUCCESS_2 = 2'b10} fc_result_t;
  typedef enum logic {FC_INIT = 1'b0, FC_ACTIVE = 1'b1} fc_state_t;

  fc_state_t state, state_next;

  // Per-type tables indexed directly by the command/type code; entry 0 (NOP) is never granted.
  logic [HW-1:0] cl_hdr  [4];
  logic [DW-1:0] cl_data [4];
  logic [HW-1:0] cc_hdr  [4];
  logic [DW-1:0] cc_data [4];
  logic [HW-1:0] cc_hdr_next  [4];
  logic [DW-1:0] cc_data_next [4];
  logic [3:0]    inf_hdr;
  logic [3:0]    inf_data;
  logic [2:0]    received;

  logic [1:0]    t1, t2;
  logic [10:0]   dreq1_w, dreq2_w;
  logic [DW-1:0] dreq1, dreq2;
  logic [HW-1:0] cc_hdr_2;
  logic [DW-1:0] cc_data_2;
  logic          pass1, pass2;
  logic          grant1, grant2;
  fc_result_t    result;

  function automatic logic hdr_ok(input logic inf, input logic [HW-1:0] cl,
                                  input logic [HW-1:0] cc, input logic [HW-1:0] req);
    logic [HW-1:0] diff;
    diff = cl - (cc + req);
    return inf || (diff <= HDR_HALF);
  endfunction

  function automatic logic data_ok(input logic inf, input logic [DW-1:0] cl,
                                   input logic [DW-1:0] cc, input logic [DW-1:0] req);
    logic [DW-1:0] diff;
    diff = cl - (cc + req);
    return inf || (diff <= DATA_HALF);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= FC_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == FC_INIT && (&received)) state_next = FC_ACTIVE;
  end

  // TLP 2 of the same type is checked as if TLP 1 had already been consumed.
  always_comb begin
    t1      = arb.Command_1;
    t2      = arb.Command_2;
    dreq1_w = ({1'b0, arb.PTLP_1} + 11'd3) >> 2;
    dreq2_w = ({1'b0, arb.PTLP_2} + 11'd3) >> 2;
    dreq1   = DW'(dreq1_w);
    dreq2   = DW'(dreq2_w);
    pass1   = hdr_ok(inf_hdr[t1], cl_hdr[t1], cc_hdr[t1], HDR_ONE) &&
              data_ok(inf_data[t1], cl_data[t1], cc_data[t1], dreq1);
    cc_hdr_2  = cc_hdr[t2];
    cc_data_2 = cc_data[t2];
    if (t2 == t1) begin
      cc_hdr_2  = cc_hdr[t1] + HDR_ONE;
      cc_data_2 = cc_data[t1] + dreq1;
    end
    pass2 = hdr_ok(inf_hdr[t2], cl_hdr[t2], cc_hdr_2, HDR_ONE) &&
            data_ok(inf_data[t2], cl_data[t2], cc_data_2, dreq2);
    result = FC_FAILED;
    if (state == FC_ACTIVE && t1 != FC_NOP && pass1) begin
      if (t2 != FC_NOP && pass2) result = FC_SUCCESS_2;
      else                       result = FC_SUCCESS_1;
    end
    grant1 = (result != FC_FAILED);
    grant2 = (result == FC_SUCCESS_2);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cc_hdr_next[i]  = cc_hdr[i];
      cc_data_next[i] = cc_data[i];
      if (grant1 && t1 == 2'(i)) begin
        cc_hdr_next[i]  = cc_hdr_next[i] + HDR_ONE;
        cc_data_next[i] = cc_data_next[i] + dreq1;
      end
      if (grant2 && t2 == 2'(i)) begin
        cc_hdr_next[i]  = cc_hdr_next[i] + HDR_ONE;
        cc_data_next[i] = cc_data_next[i] + dreq2;
      end
    end
  end

  // InitFC is only honoured while initialising and UpdateFC only once active.
  always_ff @(posedge clk) begin
    if (rst) begin
      inf_hdr  <= '0;
      inf_data <= '0;
      received <= '0;
      for (int i = 0; i < 4; i++) begin
        cl_hdr[i]  <= '0;
        cl_data[i] <= '0;
        cc_hdr[i]  <= '0;
        cc_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cc_hdr[i]  <= cc_hdr_next[i];
        cc_data[i] <= cc_data_next[i];
      end
      if (fc_update_valid && fc_update_type != FC_NOP) begin
        if (state == FC_INIT && fc_update_init) begin
          cl_hdr[fc_update_type]   <= fc_update_hdr;
          cl_data[fc_update_type]  <= fc_update_data;
          inf_hdr[fc_update_type]  <= (fc_update_hdr == '0);
          inf_data[fc_update_type] <= (fc_update_data == '0);
          received[fc_update_type - 2'd1] <= 1'b1;
        end else if (state == FC_ACTIVE && !fc_update_init) begin
          if (!inf_hdr[fc_update_type])  cl_hdr[fc_update_type]  <= fc_update_hdr;
          if (!inf_data[fc_update_type]) cl_data[fc_update_type] <= fc_update_data;
        end
      end
    end
  end

  assign arb.Result     = result;
  assign fc_initialized = (state == FC_ACTIVE);

endmodule
